// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Sequences interrupt entry and exit for a simple CPU control unit. A pending
// NMI (rising-edge captured) or an enabled, level-held IRQ is taken at the
// next safe instruction boundary. The controller saves the PC, vectors, runs
// the handler until eret, then restores the PC and the interrupt-enable bit.
// Handlers do not nest.
//
// Parameters
//   NMI_VECTOR     : PC target for non-maskable entry
//   IRQ_VECTOR     : PC target for maskable entry
// Ports
//   clock          : rising-edge clock
//   reset_n        : asynchronous active-low reset
//   nmi            : non-maskable request, rising-edge sensitive
//   irq            : maskable request, level held until irq_ack
//   instr_boundary : control unit is at a safe preemption point
//   cpu_busy       : blocks interrupt entry while high
//   eret           : return-from-interrupt pulse (used only in SERVICE)
//   ie_set/ie_clr  : set / clear interrupt enable (clear wins)
//   save_pc        : pulse, capture PC into saved-PC register
//   pc_vector      : pulse, load PC from vector_addr
//   vector_addr    : vector of the request being served (0 outside entry)
//   pc_restore     : pulse, load PC from saved PC
//   irq_ack        : pulse in the vector cycle of a maskable entry
//   in_service     : handler running
//   in_nmi         : running handler is the NMI handler
//   ie             : interrupt-enable bit
// Build option
//   INT_CTRL_INPUT_SYNC_EN : adds 2-flop synchronizers on nmi and irq
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter logic [31:0] NMI_VECTOR = 32'd20,
  parameter logic [31:0] IRQ_VECTOR = 32'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        nmi,
  input  logic        irq,
  input  logic        instr_boundary,
  input  logic        cpu_busy,
  input  logic        eret,
  input  logic        ie_set,
  input  logic        ie_clr,
  output logic        save_pc,
  output logic        pc_vector,
  output logic [31:0] vector_addr,
  output logic        pc_restore,
  output logic        irq_ack,
  output logic        in_service,
  output logic        in_nmi,
  output logic        ie
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SAVE,
    ST_VECTOR,
    ST_SERVICE,
    ST_RESTORE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_nmi;
  logic        w_irq;
  logic        w_nmi_edge;
  logic        w_req;
  logic        w_take;
  logic        w_served_nxt;
  logic        w_ie_nxt;

  logic        r_nmi_prev;
  logic        r_nmi_pend;
  logic        r_ie;
  logic        r_ie_saved;
  logic        r_served_nmi;

  logic        r_save_pc;
  logic        r_pc_vector;
  logic        r_pc_restore;
  logic        r_irq_ack;
  logic        r_in_service;
  logic        r_in_nmi;
  logic [31:0] r_vector_addr;

`ifdef INT_CTRL_INPUT_SYNC_EN
  localparam int unsigned SYNC_W = 2;
  logic [SYNC_W-1:0] r_nmi_sync;
  logic [SYNC_W-1:0] r_irq_sync;

  // Two-stage synchronizers for the asynchronous request lines
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_nmi_sync <= '0;
      r_irq_sync <= '0;
    end else begin
      r_nmi_sync <= {r_nmi_sync[0], nmi};
      r_irq_sync <= {r_irq_sync[0], irq};
    end
  end

  assign w_nmi = r_nmi_sync[SYNC_W-1];
  assign w_irq = r_irq_sync[SYNC_W-1];
`else
  assign w_nmi = nmi;
  assign w_irq = irq;
`endif

  assign w_nmi_edge = w_nmi & ~r_nmi_prev;
  // NMI outranks IRQ; IRQ only counts while enabled
  assign w_req      = r_nmi_pend | (w_irq & r_ie);

  // Next state, served-source capture and enable-bit update
  always_comb begin
    w_state_nxt  = r_state;
    w_take       = 1'b0;
    w_ie_nxt     = r_ie;
    case (r_state)
      ST_IDLE:    if (w_req) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (instr_boundary && !cpu_busy) begin
          w_state_nxt = ST_SAVE;
          w_take      = 1'b1;
        end
      end
      ST_SAVE:    w_state_nxt = ST_VECTOR;
      ST_VECTOR:  w_state_nxt = ST_SERVICE;
      ST_SERVICE: if (eret) w_state_nxt = ST_RESTORE;
      ST_RESTORE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase

    // Enable-bit software writes are locked out while saving/restoring
    case (r_state)
      ST_SAVE:    w_ie_nxt = 1'b0;
      ST_RESTORE: w_ie_nxt = r_ie_saved;
      default: begin
        if (ie_clr)      w_ie_nxt = 1'b0;
        else if (ie_set) w_ie_nxt = 1'b1;
      end
    endcase

    w_served_nxt = w_take ? r_nmi_pend : r_served_nmi;
  end

  // State register with outputs registered from the next-state decode
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_save_pc     <= 1'b0;
      r_pc_vector   <= 1'b0;
      r_pc_restore  <= 1'b0;
      r_irq_ack     <= 1'b0;
      r_in_service  <= 1'b0;
      r_in_nmi      <= 1'b0;
      r_vector_addr <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_save_pc     <= (w_state_nxt == ST_SAVE);
      r_pc_vector   <= (w_state_nxt == ST_VECTOR);
      r_pc_restore  <= (w_state_nxt == ST_RESTORE);
      r_irq_ack     <= (w_state_nxt == ST_VECTOR) && !w_served_nxt;
      r_in_service  <= (w_state_nxt == ST_SERVICE);
      r_in_nmi      <= (w_state_nxt == ST_SERVICE) && w_served_nxt;
      r_vector_addr <= ((w_state_nxt == ST_SAVE) || (w_state_nxt == ST_VECTOR)) ?
                       (w_served_nxt ? NMI_VECTOR : IRQ_VECTOR) : '0;
    end
  end

  // Request capture, enable bit and served-source flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_nmi_prev   <= 1'b0;
      r_nmi_pend   <= 1'b0;
      r_ie         <= 1'b0;
      r_ie_saved   <= 1'b0;
      r_served_nmi <= 1'b0;
    end else begin
      r_nmi_prev   <= w_nmi;
      // A fresh edge wins over the clear so it is never lost
      r_nmi_pend   <= w_nmi_edge | (r_nmi_pend & ~w_take);
      r_ie         <= w_ie_nxt;
      r_served_nmi <= w_served_nxt;
      if (r_state == ST_SAVE) r_ie_saved <= r_ie;
    end
  end

  assign save_pc     = r_save_pc;
  assign pc_vector   = r_pc_vector;
  assign pc_restore  = r_pc_restore;
  assign irq_ack     = r_irq_ack;
  assign in_service  = r_in_service;
  assign in_nmi      = r_in_nmi;
  assign vector_addr = r_vector_addr;
  assign ie          = r_ie;

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
// Directed scenario tables plus a randomized run checked against a
// handler-sequence reference model. Flag vector order everywhere:
// {save_pc, pc_vector, pc_restore, irq_ack, in_service, in_nmi, ie}.
// Stimulus vector order:
// {nmi, irq, instr_boundary, cpu_busy, eret, ie_set, ie_clr}.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

  localparam logic [31:0] NMI_V = 32'd20;
  localparam logic [31:0] IRQ_V = 32'd0;

  typedef struct packed {
    logic [6:0]  stim;
    logic [6:0]  want;
    logic [31:0] addr;
  } step_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        nmi, irq, instr_boundary, cpu_busy, eret, ie_set, ie_clr;
  logic        save_pc, pc_vector, pc_restore, irq_ack, in_service, in_nmi, ie;
  logic [31:0] vector_addr;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit m_prev, m_pend, m_ie, m_ie_saved, m_served, m_waiting, m_restoring;
  int m_hcyc;  // 0: no handler, 1: save, 2: vector, 3+: service

  always #5 clock = ~clock;

  interrupt_controller #(.NMI_VECTOR(NMI_V), .IRQ_VECTOR(IRQ_V)) dut (
    .clock(clock), .reset_n(reset_n), .nmi(nmi), .irq(irq),
    .instr_boundary(instr_boundary), .cpu_busy(cpu_busy), .eret(eret),
    .ie_set(ie_set), .ie_clr(ie_clr), .save_pc(save_pc), .pc_vector(pc_vector),
    .vector_addr(vector_addr), .pc_restore(pc_restore), .irq_ack(irq_ack),
    .in_service(in_service), .in_nmi(in_nmi), .ie(ie)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by 500000 ns");
    $fatal(1);
  end

  function automatic logic [6:0] flags();
    return {save_pc, pc_vector, pc_restore, irq_ack, in_service, in_nmi, ie};
  endfunction

  task automatic drive(input logic [6:0] v);
    {nmi, irq, instr_boundary, cpu_busy, eret, ie_set, ie_clr} = v;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(7'b0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(7'b0110010);
    tick();
    vectors++;
    if (flags() !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want %b", flags(), 7'b0);
    end
    vectors++;
    if (vector_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_addr: got %0d want 0", vector_addr);
    end
    drive(7'b0);
    #1 reset_n = 1'b1;
    tick();
    vectors++;
    if ({flags(), vector_addr} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_release: got flags=%b addr=%0d want all zero", flags(), vector_addr);
    end
  endtask

  // ie_set then a held irq: WAIT, SAVE, VECTOR with ack, service, return
  task automatic test_irq_entry();
    step_t tbl [7] = '{
      '{7'b0110010, 7'b0000001, 32'd0},
      '{7'b0110000, 7'b0000001, 32'd0},
      '{7'b0110000, 7'b1000001, 32'd0},
      '{7'b0110000, 7'b0101000, 32'd0},
      '{7'b0010000, 7'b0000100, 32'd0},
      '{7'b0010100, 7'b0010000, 32'd0},
      '{7'b0010000, 7'b0000001, 32'd0}};
    foreach (tbl[i]) begin
      drive(tbl[i].stim);
      tick();
      vectors++;
      if ({flags(), vector_addr} !== {tbl[i].want, tbl[i].addr}) begin
        miscompares++;
        $display("FAIL irq_entry step %0d: got flags=%b addr=%0d want flags=%b addr=%0d",
                 i, flags(), vector_addr, tbl[i].want, tbl[i].addr);
      end
    end
  endtask

  // nmi and irq together: NMI served first, IRQ entry follows the return
  task automatic test_nmi_irq_priority();
    step_t tbl [12] = '{
      '{7'b1110000, 7'b0000001, 32'd0},
      '{7'b1110000, 7'b1000001, 32'd20},
      '{7'b1110000, 7'b0100000, 32'd20},
      '{7'b0110000, 7'b0000110, 32'd0},
      '{7'b0110100, 7'b0010000, 32'd0},
      '{7'b0110000, 7'b0000001, 32'd0},
      '{7'b0110000, 7'b0000001, 32'd0},
      '{7'b0110000, 7'b1000001, 32'd0},
      '{7'b0110000, 7'b0101000, 32'd0},
      '{7'b0010000, 7'b0000100, 32'd0},
      '{7'b0010100, 7'b0010000, 32'd0},
      '{7'b0010000, 7'b0000001, 32'd0}};
    foreach (tbl[i]) begin
      drive(tbl[i].stim);
      tick();
      vectors++;
      if ({flags(), vector_addr} !== {tbl[i].want, tbl[i].addr}) begin
        miscompares++;
        $display("FAIL nmi_irq_priority step %0d: got flags=%b addr=%0d want flags=%b addr=%0d",
                 i, flags(), vector_addr, tbl[i].want, tbl[i].addr);
      end
    end
  endtask

  // NMI held off by cpu_busy; save_pc one cycle after busy drops
  task automatic test_busy_stall();
    step_t tbl [11] = '{
      '{7'b1011000, 7'b0000001, 32'd0},
      '{7'b0011000, 7'b0000001, 32'd0},
      '{7'b0011000, 7'b0000001, 32'd0},
      '{7'b0011000, 7'b0000001, 32'd0},
      '{7'b0011000, 7'b0000001, 32'd0},
      '{7'b0011000, 7'b0000001, 32'd0},
      '{7'b0010000, 7'b1000001, 32'd20},
      '{7'b0010000, 7'b0100000, 32'd20},
      '{7'b0010000, 7'b0000110, 32'd0},
      '{7'b0010100, 7'b0010000, 32'd0},
      '{7'b0010000, 7'b0000001, 32'd0}};
    foreach (tbl[i]) begin
      drive(tbl[i].stim);
      tick();
      vectors++;
      if ({flags(), vector_addr} !== {tbl[i].want, tbl[i].addr}) begin
        miscompares++;
        $display("FAIL busy_stall step %0d: got flags=%b addr=%0d want flags=%b addr=%0d",
                 i, flags(), vector_addr, tbl[i].want, tbl[i].addr);
      end
    end
  endtask

  // eret in IDLE ignored; NMI edge inside a handler is served after return
  task automatic test_eret_and_nested_nmi();
    step_t tbl [17] = '{
      '{7'b0000100, 7'b0000001, 32'd0},
      '{7'b0010000, 7'b0000001, 32'd0},
      '{7'b1010000, 7'b0000001, 32'd0},
      '{7'b0010000, 7'b0000001, 32'd0},
      '{7'b0010000, 7'b1000001, 32'd20},
      '{7'b0010000, 7'b0100000, 32'd20},
      '{7'b0010000, 7'b0000110, 32'd0},
      '{7'b1010000, 7'b0000110, 32'd0},
      '{7'b0010000, 7'b0000110, 32'd0},
      '{7'b0010100, 7'b0010000, 32'd0},
      '{7'b0010000, 7'b0000001, 32'd0},
      '{7'b0010000, 7'b0000001, 32'd0},
      '{7'b0010000, 7'b1000001, 32'd20},
      '{7'b0010000, 7'b0100000, 32'd20},
      '{7'b0010000, 7'b0000110, 32'd0},
      '{7'b0010100, 7'b0010000, 32'd0},
      '{7'b0010000, 7'b0000001, 32'd0}};
    foreach (tbl[i]) begin
      drive(tbl[i].stim);
      tick();
      vectors++;
      if ({flags(), vector_addr} !== {tbl[i].want, tbl[i].addr}) begin
        miscompares++;
        $display("FAIL eret_nested_nmi step %0d: got flags=%b addr=%0d want flags=%b addr=%0d",
                 i, flags(), vector_addr, tbl[i].want, tbl[i].addr);
      end
    end
  endtask

  // irq withdrawn in WAIT: back to IDLE, so a later entry takes the full 2 cycles
  task automatic test_irq_withdraw();
    step_t tbl [11] = '{
      '{7'b0000010, 7'b0000001, 32'd0},
      '{7'b0100000, 7'b0000001, 32'd0},
      '{7'b0100000, 7'b0000001, 32'd0},
      '{7'b0000000, 7'b0000001, 32'd0},
      '{7'b0000000, 7'b0000001, 32'd0},
      '{7'b0110000, 7'b0000001, 32'd0},
      '{7'b0110000, 7'b1000001, 32'd0},
      '{7'b0110000, 7'b0101000, 32'd0},
      '{7'b0010000, 7'b0000100, 32'd0},
      '{7'b0010100, 7'b0010000, 32'd0},
      '{7'b0010000, 7'b0000001, 32'd0}};
    foreach (tbl[i]) begin
      drive(tbl[i].stim);
      tick();
      vectors++;
      if ({flags(), vector_addr} !== {tbl[i].want, tbl[i].addr}) begin
        miscompares++;
        $display("FAIL irq_withdraw step %0d: got flags=%b addr=%0d want flags=%b addr=%0d",
                 i, flags(), vector_addr, tbl[i].want, tbl[i].addr);
      end
    end
  endtask

  // Reset asserted in VECTOR clears everything at once; nothing follows
  task automatic test_reset_mid_sequence();
    drive(7'b1010000);
    repeat (4) tick();
    vectors++;
    if ({pc_vector, vector_addr} !== {1'b1, NMI_V}) begin
      miscompares++;
      $display("FAIL reset_mid_reach_vector: got pc_vector=%b addr=%0d want 1 and %0d",
               pc_vector, vector_addr, NMI_V);
    end
    drive(7'b0);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({flags(), vector_addr} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got flags=%b addr=%0d want all zero", flags(), vector_addr);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    drive(7'b0010100);
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if ({flags(), vector_addr} !== 39'd0) begin
        miscompares++;
        $display("FAIL reset_mid_after cycle %0d: got flags=%b addr=%0d want all zero",
                 k, flags(), vector_addr);
      end
    end
    drive(7'b0);
  endtask

  // Reference model: one clock of the interrupt sequencing rules
  task automatic model_step();
    bit edge_seen, req, take;
    edge_seen = nmi && !m_prev;
    m_prev    = nmi;
    req       = m_pend || (irq && m_ie);
    take      = 1'b0;
    if (m_restoring) begin
      m_restoring = 1'b0;
      m_ie        = m_ie_saved;
    end else if (m_hcyc != 0) begin
      if (m_hcyc == 1) begin
        m_ie_saved = m_ie;
        m_ie       = 1'b0;
      end else begin
        m_ie = ie_clr ? 1'b0 : (ie_set ? 1'b1 : m_ie);
      end
      if (m_hcyc >= 3 && eret) begin
        m_hcyc      = 0;
        m_restoring = 1'b1;
      end else if (m_hcyc < 3) begin
        m_hcyc = m_hcyc + 1;
      end
    end else begin
      m_ie = ie_clr ? 1'b0 : (ie_set ? 1'b1 : m_ie);
      if (!m_waiting) begin
        m_waiting = req;
      end else if (!req) begin
        m_waiting = 1'b0;
      end else if (instr_boundary && !cpu_busy) begin
        m_waiting = 1'b0;
        m_hcyc    = 1;
        m_served  = m_pend;
        take      = 1'b1;
      end
    end
    m_pend = edge_seen || (m_pend && !take);
  endtask

  task automatic test_random();
    logic [6:0]  want;
    logic [31:0] want_addr;
    int          printed = 0;
    do_reset();
    {m_prev, m_pend, m_ie, m_ie_saved, m_served, m_waiting, m_restoring} = '0;
    m_hcyc = 0;
    want   = 7'b0;
    for (int c = 0; c < 2000; c++) begin
      nmi            = ($urandom_range(0, 15) == 0);
      if (!irq)                         irq = ($urandom_range(0, 7) == 0);
      else if (want[3])                 irq = 1'b0;
      else if ($urandom_range(0, 31) == 0) irq = 1'b0;
      instr_boundary = ($urandom_range(0, 1) == 0);
      cpu_busy       = ($urandom_range(0, 3) == 0);
      eret           = ($urandom_range(0, 5) == 0);
      ie_set         = ($urandom_range(0, 7) == 0);
      ie_clr         = ($urandom_range(0, 11) == 0);
      @(posedge clock);
      model_step();
      #1;
      want = {m_hcyc == 1, m_hcyc == 2, m_restoring, (m_hcyc == 2) && !m_served,
              m_hcyc >= 3, (m_hcyc >= 3) && m_served, m_ie};
      want_addr = (m_hcyc == 1 || m_hcyc == 2) ? (m_served ? NMI_V : IRQ_V) : 32'd0;
      vectors++;
      if ({flags(), vector_addr} !== {want, want_addr}) begin
        miscompares++;
        if (printed < 10) begin
          printed++;
          $display("FAIL random cycle %0d: got flags=%b addr=%0d want flags=%b addr=%0d",
                   c, flags(), vector_addr, want, want_addr);
        end
      end
    end
    drive(7'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(7'b0);
    test_reset();
    test_irq_entry();
    test_nmi_irq_priority();
    test_busy_stall();
    test_eret_and_nested_nmi();
    test_irq_withdraw();
    test_reset_mid_sequence();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NMI_VECTOR, default 32'd20, PC target for non-maskable interrupt entry.
REQ-002 Parameter IRQ_VECTOR, default 32'd0, PC target for maskable interrupt entry.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 nmi  input  1  non-maskable request; rising-edge sensitive.
REQ-006 irq  input  1  maskable request; level sensitive; held by source until irq_ack.
REQ-007 instr_boundary  input  1  high while the control unit is in its fetch state (safe preemption point).
REQ-008 cpu_busy  input  1  high blocks interrupt entry.
REQ-009 eret  input  1  one-cycle pulse: return-from-interrupt decoded.
REQ-010 ie_set / ie_clr  input  1 each  set / clear the interrupt-enable bit.
REQ-011 save_pc  output  1  one-cycle pulse; enables the saved-PC register.
REQ-012 pc_vector  output  1  one-cycle pulse; forces PC load with vector_addr.
REQ-013 vector_addr  output  32  NMI_VECTOR or IRQ_VECTOR per the request being served.
REQ-014 pc_restore  output  1  one-cycle pulse; forces PC load from saved PC.
REQ-015 irq_ack  output  1  one-cycle pulse in the vector cycle of a maskable entry.
REQ-016 in_service / in_nmi / ie  output  1 each  handler active / active handler is NMI / enable bit.

Function
REQ-017 FSM states IDLE, WAIT, SAVE, VECTOR, SERVICE, RESTORE; one-hot or binary encoding is free.
REQ-018 nmi rising edge (registered previous sample) SHALL set nmi_pend, from any state.
REQ-019 nmi_pend SHALL clear only on entry to SAVE for an NMI.
REQ-020 IDLE -> WAIT when nmi_pend=1 or (irq=1 and ie=1).
REQ-021 WAIT -> SAVE when instr_boundary=1 and cpu_busy=0.
REQ-022 WAIT -> IDLE when the request is gone: nmi_pend=0 and (irq=0 or ie=0).
REQ-023 In WAIT, the source SHALL be re-evaluated every cycle; NMI has priority.
REQ-024 The source SHALL be frozen in a served_nmi flag on the WAIT -> SAVE transition.
REQ-025 SAVE, exactly one cycle: save_pc=1; ie_saved<=ie; ie<=0.
REQ-026 VECTOR, exactly one cycle: pc_vector=1; irq_ack=1 if not served_nmi. Latency from qualifying boundary cycle to pc_vector is 2 cycles.
REQ-027 vector_addr SHALL be held stable from SAVE through VECTOR; value is 0 in all other states.
REQ-028 SERVICE: in_service=1 and in_nmi=served_nmi; leave only on eret=1, to RESTORE.
REQ-029 RESTORE, exactly one cycle: pc_restore=1; ie<=ie_saved; then -> IDLE.
REQ-030 eret outside SERVICE SHALL be ignored.
REQ-031 No nesting: requests arriving in SAVE..RESTORE stay pending and are evaluated from IDLE.
REQ-032 Simultaneous NMI and IRQ: NMI is served; IRQ remains pending if still asserted.
REQ-033 ie_set and ie_clr both high: clear wins.
REQ-034 ie_set/ie_clr SHALL be ignored in SAVE and RESTORE.
REQ-035 save_pc, pc_vector and pc_restore SHALL be mutually exclusive.

Reset
REQ-036 reset_n low: state=IDLE; nmi_pend=0; nmi previous sample=0; ie=0; ie_saved=0; served_nmi=0; all outputs 0.
REQ-037 Reset asserted mid-sequence SHALL abort immediately with no further pulses.

Configuration
REQ-038 Macro INT_CTRL_INPUT_SYNC_EN defined: nmi and irq each pass through a 2-flop synchronizer reset to 0, adding 2 cycles of request latency.
REQ-039 Macro INT_CTRL_INPUT_SYNC_EN undefined: inputs are used directly; all other behaviour is identical.

Verification
REQ-040 ie_set, irq=1, boundary=1 (sync off) -> WAIT; save_pc next cycle; pc_vector, irq_ack and vector_addr=0 the cycle after; ie=0.
REQ-041 nmi and irq rise in the same cycle, ie=1 -> vector_addr=20, in_nmi=1, no irq_ack; after eret, pc_restore, then the IRQ entry follows.
REQ-042 nmi edge with cpu_busy=1 for 5 cycles -> no save_pc; save_pc 1 cycle after busy drops while boundary=1.
REQ-043 eret pulse in IDLE -> no pc_restore; nmi edge during SERVICE -> served right after RESTORE/IDLE.
REQ-044 reset_n low during VECTOR -> all outputs 0 at once; ie=0; no pc_restore after release.
REQ-045 irq drops while in WAIT with boundary=0 -> back to IDLE; no pulses.
